// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and defaults for the alu_seq sequencer and its
//               combinational execute unit (opcodes, FSM states, widths).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHW_DEF  = 5;

    // 4-bit opcode encodings; any code not listed passes opA through
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_XOR  = 4'h2,
        OP_OR   = 4'h3,
        OP_AND  = 4'h4,
        OP_SLT  = 4'h5,
        OP_SLTU = 4'h6,
        OP_SLL  = 4'h7,
        OP_SRL  = 4'h8,
        OP_SRA  = 4'h9,
        OP_PASS = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_seq_state_e;

    // True for the three shift opcodes, which take the shift path
    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle between the two requesters plus the
//               result consumer (master) and the alu_seq sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][XLEN-1:0]  req_opA;
    logic [1:0][XLEN-1:0]  req_opB;
    logic [1:0][3:0]       req_sel;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [XLEN-1:0]       rsp_data;
    logic                  busy;

    modport master (
        output req_valid, req_opA, req_opB, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_opA, req_opB, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : Purely combinational execute unit: full result for the
//               non-shift opcodes and a one-bit step for the shift opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [3:0]      i_sel,
    input  logic [XLEN-1:0] i_step_in,
    input  logic [3:0]      i_step_sel,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_step
);

    // Non-shift result; shift codes fall through to opA (handled by the sequencer)
    always_comb begin
        o_result = i_op_a;
        case (i_sel)
            OP_ADD:  o_result = i_op_a + i_op_b;
            OP_SUB:  o_result = i_op_a - i_op_b;
            OP_XOR:  o_result = i_op_a ^ i_op_b;
            OP_OR:   o_result = i_op_a | i_op_b;
            OP_AND:  o_result = i_op_a & i_op_b;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
            default: o_result = i_op_a;
        endcase
    end

    // Single-bit shift step in the direction/type given by the latched opcode
    always_comb begin
        o_step = i_step_in;
        case (i_step_sel)
            OP_SLL:  o_step = {i_step_in[XLEN-2:0], 1'b0};
            OP_SRL:  o_step = {1'b0, i_step_in[XLEN-1:1]};
            OP_SRA:  o_step = {i_step_in[XLEN-1], i_step_in[XLEN-1:1]};
            default: o_step = i_step_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Round-robin sequencer for two requesters in front of a shared
//               integer ALU. One operation in flight; shifts iterate one bit
//               per cycle unless ALU_SEQ_FAST_SHIFT_EN is defined, in which
//               case a single-cycle shifter is used and SHIFT is not built.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = SHW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    alu_seq_state_e  r_state;
    logic            r_last;
    logic            r_id;
    logic [XLEN-1:0] r_acc;
`ifndef ALU_SEQ_FAST_SHIFT_EN
    logic [3:0]      r_sel;
    logic [SHW-1:0]  r_cnt;
`endif

    logic            w_gnt;
    logic [1:0]      w_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [3:0]      w_sel;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_step;

    // Round-robin pick: contested -> the port not granted last time
    always_comb begin
        w_gnt   = bus.req_valid[1];
        w_ready = 2'b00;
        if (bus.req_valid == 2'b11) begin
            w_gnt = ~r_last;
        end
        if (rst_n && (r_state == IDLE) && (bus.req_valid != 2'b00)) begin
            w_ready = w_gnt ? 2'b10 : 2'b01;
        end
    end

    assign w_accept      = |w_ready;
    assign w_op_a        = bus.req_opA[w_gnt];
    assign w_op_b        = bus.req_opB[w_gnt];
    assign w_sel         = bus.req_sel[w_gnt];
    assign w_shamt       = w_op_b[SHW-1:0];

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_data  = r_acc;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = (r_state != IDLE);

    alu_exec #(
        .XLEN       (XLEN)
    ) u_exec (
        .i_op_a     (w_op_a),
        .i_op_b     (w_op_b),
        .i_sel      (w_sel),
        .i_step_in  (r_acc),
`ifndef ALU_SEQ_FAST_SHIFT_EN
        .i_step_sel (r_sel),
`else
        .i_step_sel (w_sel),
`endif
        .o_result   (w_result),
        .o_step     (w_step)
    );

`ifdef ALU_SEQ_FAST_SHIFT_EN
    logic [XLEN-1:0] w_shift_full;

    // Single-cycle shifter used only in the fast build
    always_comb begin
        w_shift_full = w_op_a;
        case (w_sel)
            OP_SLL:  w_shift_full = w_op_a << w_shamt;
            OP_SRL:  w_shift_full = w_op_a >> w_shamt;
            OP_SRA:  w_shift_full = $signed(w_op_a) >>> w_shamt;
            default: w_shift_full = w_op_a;
        endcase
    end
`endif

    // Sequencer FSM: accept in IDLE, iterate in SHIFT, hold result in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_acc   <= '0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
            r_sel   <= 4'h0;
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id   <= w_gnt;
                        r_last <= w_gnt;
                        if (is_shift(w_sel)) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                            r_acc   <= w_shift_full;
                            r_state <= DONE;
`else
                            r_acc <= w_op_a;
                            r_sel <= w_sel;
                            if (w_shamt == '0) begin
                                r_state <= DONE;
                            end else begin
                                r_cnt   <= w_shamt;
                                r_state <= SHIFT;
                            end
`endif
                        end else begin
                            r_acc   <= w_result;
                            r_state <= DONE;
                        end
                    end
                end
`ifndef ALU_SEQ_FAST_SHIFT_EN
                SHIFT: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed and random ops
//               against an arithmetic reference model, arbitration order,
//               shift latency, backpressure and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(32)) bus();

    alu_seq #(
        .XLEN (32),
        .SHW  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference result computed directly from the opcode table
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a ^ b;
            4'h3: return a | b;
            4'h4: return a & b;
            4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: return (a < b) ? 32'd1 : 32'd0;
            4'h7: return a << sh;
            4'h8: return a >> sh;
            4'h9: return 32'($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Expected accept-to-response latency in cycles
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        if (op == 4'h7 || op == 4'h8 || op == 4'h9) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single-port operation: grant, latency, data, id, then response handshake
    task automatic do_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        int lat;
        @(negedge clk);
        bus.req_valid    = 2'b00;
        bus.req_valid[p] = 1'b1;
        bus.req_opA[p]   = a;
        bus.req_opB[p]   = b;
        bus.req_sel[p]   = op;
        bus.rsp_ready    = 1'b0;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("op_grant", 32'(bus.req_ready), (p == 1) ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("op_latency", 32'(lat), 32'(ref_lat(op, b)));
        chk("op_data", bus.rsp_data, ref_alu(op, a, b));
        chk("op_id", 32'(bus.rsp_id), 32'(p));
        chk("op_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("op_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int ng;
        int nr;
        logic pend;
        logic [31:0] held_data;

        bus.req_valid = 2'b11;
        bus.req_opA   = '0;
        bus.req_opB   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, with requests pending during reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD on port 0
        do_op(0, OP_ADD, 32'h5, 32'h3);
        chk("add_const", bus.rsp_data, 32'h8);

        // Both ports valid continuously: grants alternate starting at port 0
        do_reset();
        @(negedge clk);
        bus.req_opA[0] = 32'd10;   bus.req_opB[0] = 32'd3;   bus.req_sel[0] = OP_SUB;
        bus.req_opA[1] = 32'hFF;   bus.req_opB[1] = 32'h0F;  bus.req_sel[1] = OP_XOR;
        bus.req_valid  = 2'b11;
        bus.rsp_ready  = 1'b1;
        ng = 0; nr = 0; pend = 1'b0;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk("dual_grant", 32'(bus.req_ready), (ng % 2 == 0) ? 32'd1 : 32'd2);
                pend = bus.req_ready[1];
                ng++;
            end
            if (bus.rsp_valid) begin
                chk("dual_id", 32'(bus.rsp_id), 32'(pend));
                chk("dual_data", bus.rsp_data, pend ? 32'hF0 : 32'h7);
                nr++;
            end
            if (nr < 4) @(negedge clk);
        end
        chk("dual_count", 32'(nr), 32'd4);
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Shifts and edge arithmetic
        do_reset();
        do_op(0, OP_SRA, 32'h8000_0000, 32'd4);
        chk("sra_const", bus.rsp_data, 32'hF800_0000);
        do_op(1, OP_SLL, 32'h1234_5678, 32'h0000_0020);
        chk("sll0_const", bus.rsp_data, 32'h1234_5678);
        do_op(0, OP_SLT,  32'hFFFF_FFFF, 32'h1);
        do_op(1, OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        do_op(0, OP_ADD,  32'hFFFF_FFFF, 32'h1);
        do_op(1, 4'hF,    32'hDEAD_BEEF, 32'h1234_0000);
        do_op(0, OP_SRL,  32'hF000_000F, 32'd31);

        // Random operations across all opcodes and both ports
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        // Backpressure: port 0 result held while port 1 waits
        do_reset();
        @(negedge clk);
        bus.req_opA[0] = 32'h5;    bus.req_opB[0] = 32'h3;   bus.req_sel[0] = OP_ADD;
        bus.req_opA[1] = 32'hA0;   bus.req_opB[1] = 32'h05;  bus.req_sel[1] = OP_OR;
        bus.req_valid  = 2'b11;
        #1;
        chk("bp_grant0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        held_data = bus.rsp_data;
        chk("bp_first", held_data, 32'h8);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", bus.rsp_data, held_data);
            chk("bp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            chk("bp_noready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("bp_grant1", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("bp_p1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_p1_data", bus.rsp_data, 32'hA5);
        chk("bp_p1_id", 32'(bus.rsp_id), 32'd1);

        // Reset in the middle of a 20-bit logical right shift
        do_reset();
        @(negedge clk);
        bus.req_opA[0] = 32'hFFFF_0000; bus.req_opB[0] = 32'd20; bus.req_sel[0] = OP_SRL;
        bus.req_opA[1] = 32'h1;         bus.req_opB[1] = 32'h2;  bus.req_sel[1] = OP_ADD;
        bus.req_valid  = 2'b01;
        #1;
        chk("rs_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("rs_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rs_busy", 32'(bus.busy), 32'd0);
        chk("rs_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_grant0", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
